// File: rtl/concat_field_deserializer_pkg.sv
// ============================================================================
// Module      : concat_pkg
// Description : Shared types and default sizes for the concatenation-stage
//               serial front end.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package concat_pkg;

    localparam int A_W_DEFAULT     = 4;
    localparam int B_W_DEFAULT     = 4;
    localparam int FRAME_DATA_BITS = A_W_DEFAULT + B_W_DEFAULT + 1;
    localparam int BIT_CNT_W       = $clog2(FRAME_DATA_BITS);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DATA      = 3'd1,
        PARITY    = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/concat_field_deserializer_if.sv
// ============================================================================
// Module      : concat_field_deserializer_if
// Description : Serial input strobe/data plus assembled field outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface concat_field_deserializer_if
    import concat_pkg::*;
#(
    parameter int A_W = A_W_DEFAULT,
    parameter int B_W = B_W_DEFAULT
);
    logic           bit_en;
    logic           sdi;
    logic [A_W-1:0] a_out;
    logic [B_W-1:0] b_out;
    logic           c_out;
    logic           frame_valid;
    logic           frame_err;
    logic           busy;

    modport master (
        output bit_en, sdi,
        input  a_out, b_out, c_out, frame_valid, frame_err, busy
    );

    modport slave (
        input  bit_en, sdi,
        output a_out, b_out, c_out, frame_valid, frame_err, busy
    );
endinterface

`default_nettype wire

// File: rtl/concat_field_deserializer_shift_reg.sv
// ============================================================================
// Module      : concat_shift_reg
// Description : MSB-first data shift register with running XOR parity.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module concat_shift_reg
    import concat_pkg::*;
#(
    parameter int WIDTH = FRAME_DATA_BITS
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             shift_en,
    input  wire logic             clr,
    input  wire logic             din,
    output logic      [WIDTH-1:0] data,
    output logic                  par
);

    logic [WIDTH-1:0] r_data;
    logic             r_par;

    // Clear wins over shift so the start-bit edge never leaks into the data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
            r_par  <= 1'b0;
        end else if (clr) begin
            r_data <= '0;
            r_par  <= 1'b0;
        end else if (shift_en) begin
            r_data <= {r_data[WIDTH-2:0], din};
            r_par  <= r_par ^ din;
        end
    end

    assign data = r_data;
    assign par  = r_par;

endmodule

`default_nettype wire

// File: rtl/concat_field_deserializer.sv
// ============================================================================
// Module      : concat_field_deserializer
// Description : Framed serial receiver producing registered a/b/c fields.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module concat_field_deserializer
    import concat_pkg::*;
#(
    parameter int A_W    = A_W_DEFAULT,
    parameter int B_W    = B_W_DEFAULT,
    parameter int PAR_EN = 1
) (
    input wire logic                   clk,
    input wire logic                   rst_n,
    concat_field_deserializer_if.slave bus
);

    localparam int c_frame_bits = A_W + B_W + 1;
    localparam int c_cnt_w      = $clog2(c_frame_bits);
    localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(c_frame_bits - 1);

    state_t                    r_state;
    state_t                    w_next;
    logic [c_cnt_w-1:0]        r_cnt;
    logic                      r_par_err;
    logic [A_W-1:0]            r_a;
    logic [B_W-1:0]            r_b;
    logic                      r_c;
    logic                      r_valid;
    logic                      r_err;

    logic                      w_clr;
    logic                      w_shift_en;
    logic                      w_par_cap;
    logic                      w_load;
    logic                      w_err;
    logic [c_frame_bits-1:0]   w_data;
    logic                      w_par;

    concat_shift_reg #(
        .WIDTH (c_frame_bits)
    ) u_shift (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_en (w_shift_en),
        .clr      (w_clr),
        .din      (bus.sdi),
        .data     (w_data),
        .par      (w_par)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_clr      = 1'b0;
        w_shift_en = 1'b0;
        w_par_cap  = 1'b0;
        w_load     = 1'b0;
        w_err      = 1'b0;
        if (bus.bit_en) begin
            case (r_state)
                IDLE: begin
                    if (!bus.sdi) begin
                        w_clr  = 1'b1;
                        w_next = DATA;
                    end
                end
                DATA: begin
                    w_shift_en = 1'b1;
                    if (r_cnt == c_last_bit) begin
                        w_next = (PAR_EN != 0) ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    w_par_cap = 1'b1;
                    w_next    = STOP;
                end
                STOP: begin
                    // A bad stop bit reports once, even when parity was also bad.
                    if (bus.sdi) begin
                        w_load = !r_par_err;
                        w_err  = r_par_err;
                        w_next = IDLE;
                    end else begin
                        w_err  = 1'b1;
                        w_next = WAIT_IDLE;
                    end
                end
                WAIT_IDLE: begin
                    if (bus.sdi) begin
                        w_next = IDLE;
                    end
                end
                default: begin
                    w_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_par_err <= 1'b0;
        end else begin
            if (w_clr) begin
                r_cnt     <= '0;
                r_par_err <= 1'b0;
            end else begin
                if (w_shift_en) begin
                    r_cnt <= r_cnt + 1'b1;
                end
                if (w_par_cap) begin
                    r_par_err <= w_par ^ bus.sdi;
                end
            end
        end
    end

    // Pulses last one clock regardless of bit_en; fields move only on a good frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= 1'b0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_valid <= w_load;
            r_err   <= w_err;
            if (w_load) begin
                r_a <= w_data[c_frame_bits-1 -: A_W];
                r_b <= w_data[B_W:1];
                r_c <= w_data[0];
            end
        end
    end

    assign bus.a_out       = r_a;
    assign bus.b_out       = r_b;
    assign bus.c_out       = r_c;
    assign bus.frame_valid = r_valid;
    assign bus.frame_err   = r_err;
    assign bus.busy        = (r_state != IDLE);

endmodule

`default_nettype wire
